mmse_frame_loader: RTL and testbench

Parametrised frame sequencer in front of the MMSE detector core. It accepts one detection problem as a serial stream of signed fixed-point words: the channel matrix H, then the received matrix y, then the noise matrix N. It presents them to the core as flat parallel buses, handles the core's start/finish handshake, captures the result x, and streams x back out word by word. It replaces file-driven, bench-only loading with synthesizable, back-to-back frame processing for any real-valued dimension.

---
 rtl/mmse_frame_loader.sv | 139 +++++++++++++
 tb/tb_mmse_frame_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmse_frame_loader.sv
// mmse_frame_loader: serial-to-parallel frame sequencer for the MMSE core.
// Streams in H, y, N (row-major signed words), hands them to the core as
// flat buses, waits on the start/finish handshake, then streams x back out.
// Optional watchdog on the WAIT state: define MMSE_LOADER_TIMEOUT_EN.
module mmse_frame_loader #(
  parameter int W       = 16,
  parameter int NR      = 4,
  parameter int NC      = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  output logic [NR*NR*W-1:0]   h_flat,
  output logic [NR*NC*W-1:0]   y_flat,
  output logic [NR*NR*W-1:0]   n_flat,
  output logic                 core_start,
  input  logic                 core_finish,
  input  logic [NR*NC*W-1:0]   x_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [15:0]          frame_cnt
`ifdef MMSE_LOADER_TIMEOUT_EN
  , output logic               timeout_err
`endif
);

  localparam int HN  = NR * NR;
  localparam int YN  = NR * NC;
  localparam int NIN = 2 * HN + YN;
  localparam int CW  = $clog2(NIN + 1);

  localparam logic [CW-1:0] LAST_IN  = CW'(NIN - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(YN - 1);
  localparam logic [CW-1:0] Y_BASE   = CW'(HN);
  localparam logic [CW-1:0] N_BASE   = CW'(HN + YN);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt;
  logic [NR*NC*W-1:0]  x_q;
  logic                in_acc;
  logic                out_acc;
  logic                wd_expire;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

`ifdef MMSE_LOADER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  // Expiry only matters when finish is absent; the next-state logic gives
  // core_finish priority on the same cycle.
  assign wd_expire = (state_q == WAIT) && (wd_cnt == WDW'(TIMEOUT - 1));

  // Watchdog: count WAIT cycles, flag a missing finish (sticky until reset).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= (state_q == WAIT) ? wd_cnt + 1'b1 : '0;
      if (wd_expire && !core_finish) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // State register.
  // NOTE: every clocked assignment is non-blocking so all flops update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; core_finish is only looked at in WAIT.
  // NOTE: default assignment first so no path leaves state_d unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_acc) state_d = LOAD;
      LOAD:    if (in_acc && cnt == LAST_IN) state_d = WAIT;
      WAIT:    if (core_finish) state_d = DRAIN;
               else if (wd_expire) state_d = IDLE;
      DRAIN:   if (out_acc && cnt == LAST_OUT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and output decode from the current state.
  always_comb begin
    in_ready   = reset && (state_q == IDLE || state_q == LOAD);
    core_start = (state_q == WAIT);
    out_valid  = (state_q == DRAIN);
    out_last   = (state_q == DRAIN) && (cnt == LAST_OUT);
    busy       = (state_q != IDLE);
    out_data   = '0;
    if (state_q == DRAIN) out_data = x_q[int'(cnt)*W +: W];
  end

  // Word counter, matrix registers, result capture and frame counter.
  // The flat buses are visible ports and must read 0 after reset, so they
  // are reset alongside the control state rather than left uninitialised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      h_flat    <= '0;
      y_flat    <= '0;
      n_flat    <= '0;
      x_q       <= '0;
      frame_cnt <= '0;
    end else begin
      if (in_acc) begin
        // cnt is 0 in IDLE, so the first word of a frame lands at index 0.
        if (cnt < Y_BASE)      h_flat[int'(cnt)*W +: W]            <= in_data;
        else if (cnt < N_BASE) y_flat[(int'(cnt) - HN)*W +: W]      <= in_data;
        else                   n_flat[(int'(cnt) - HN - YN)*W +: W] <= in_data;
        cnt <= (cnt == LAST_IN) ? '0 : cnt + 1'b1;
      end else if (out_acc) begin
        cnt <= (cnt == LAST_OUT) ? '0 : cnt + 1'b1;
      end

      if (state_q == WAIT && core_finish) x_q <= x_flat;

      if (out_acc && cnt == LAST_OUT) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mmse_frame_loader.sv
// Directed bench for mmse_frame_loader: a default 4x4/NC=2 instance (a_*)
// and a 2x2/NC=1 instance (b_*). The core is stubbed inline by the stimulus.
module tb_mmse_frame_loader;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Default instance.
  logic          a_in_valid, a_in_ready, a_core_start, a_core_finish;
  logic          a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [15:0]   a_in_data, a_out_data, a_frame_cnt;
  logic [255:0]  a_h_flat, a_n_flat;
  logic [127:0]  a_y_flat, a_x_flat;
  // Small instance.
  logic          b_in_valid, b_in_ready, b_core_start, b_core_finish;
  logic          b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [15:0]   b_in_data, b_out_data, b_frame_cnt;
  logic [63:0]   b_h_flat, b_n_flat;
  logic [31:0]   b_y_flat, b_x_flat;
`ifdef MMSE_LOADER_TIMEOUT_EN
  logic          a_timeout_err, b_timeout_err;
`endif

  logic [15:0]   words [40];

  mmse_frame_loader #(.W(16), .NR(4), .NC(2), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .h_flat(a_h_flat), .y_flat(a_y_flat), .n_flat(a_n_flat),
    .core_start(a_core_start), .core_finish(a_core_finish), .x_flat(a_x_flat),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy), .frame_cnt(a_frame_cnt)
`ifdef MMSE_LOADER_TIMEOUT_EN
    , .timeout_err(a_timeout_err)
`endif
  );

  mmse_frame_loader #(.W(16), .NR(2), .NC(1)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .h_flat(b_h_flat), .y_flat(b_y_flat), .n_flat(b_n_flat),
    .core_start(b_core_start), .core_finish(b_core_finish), .x_flat(b_x_flat),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .frame_cnt(b_frame_cnt)
`ifdef MMSE_LOADER_TIMEOUT_EN
    , .timeout_err(b_timeout_err)
`endif
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present words[lo..hi] to instance a, optionally with an idle cycle before each.
  task automatic send_a(input int lo, input int hi, input bit gap);
    for (int k = lo; k <= hi; k++) begin
      if (gap) begin
        a_in_valid = 1'b0;
        tick();
      end
      a_in_valid = 1'b1;
      a_in_data  = words[k];
      check("a_in_ready", a_in_ready, 1'b1);
      if (k == 39) check("a_start_before_last", a_core_start, 1'b0);
      tick();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic check_flats_a();
    logic [255:0] he, ne;
    logic [127:0] ye;
    for (int k = 0; k < 16; k++) he[k*16 +: 16] = words[k];
    for (int k = 0; k < 8; k++)  ye[k*16 +: 16] = words[16 + k];
    for (int k = 0; k < 16; k++) ne[k*16 +: 16] = words[24 + k];
    check("a_h_flat", a_h_flat, he);
    check("a_y_flat", a_y_flat, ye);
    check("a_n_flat", a_n_flat, ne);
  endtask

  // Core stub: finish 10 cycles after start with x = base+1..base+8, then drain.
  task automatic finish_drain_a(input logic [15:0] base, input bit stall);
    int j, st, budget;
    check("a_start_high", a_core_start, 1'b1);
    check("a_in_ready_wait", a_in_ready, 1'b0);
    repeat (9) tick();
    check("a_start_still_high", a_core_start, 1'b1);
    check_flats_a();
    for (int i = 0; i < 8; i++) a_x_flat[i*16 +: 16] = 16'(base + i + 1);
    a_core_finish = 1'b1;
    tick();
    a_core_finish = 1'b0;
    a_x_flat      = '0;
    check("a_start_dropped", a_core_start, 1'b0);
    check("a_out_valid_rise", a_out_valid, 1'b1);
    j = 0; st = 0; budget = 0;
    while (j < 8 && budget < 40) begin
      if (stall && j == 3 && st < 3) begin
        a_out_ready = 1'b0;
        st++;
      end else begin
        a_out_ready = 1'b1;
      end
      check("a_out_valid", a_out_valid, 1'b1);
      check("a_out_data", a_out_data, 16'(base + j + 1));
      check("a_out_last", a_out_last, j == 7);
      if (a_out_ready) j++;
      tick();
      budget++;
    end
    a_out_ready = 1'b1;
    check("a_drain_words", j, 8);
    check("a_busy_after", a_busy, 1'b0);
    check("a_out_valid_after", a_out_valid, 1'b0);
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_data = '0; a_core_finish = 1'b0; a_x_flat = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_core_finish = 1'b0; b_x_flat = '0; b_out_ready = 1'b1;

    // Reset state.
    #2 reset = 1'b0;
    #10;
    check("rst_in_ready", a_in_ready, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, 16'h0);
    check("rst_out_last", a_out_last, 1'b0);
    check("rst_core_start", a_core_start, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_frame_cnt", a_frame_cnt, 16'h0);
    check("rst_h_flat", a_h_flat, '0);
    check("rst_y_flat", a_y_flat, '0);
    check("rst_n_flat", a_n_flat, '0);
`ifdef MMSE_LOADER_TIMEOUT_EN
    check("rst_timeout_err", a_timeout_err, 1'b0);
`endif
    tick();
    reset = 1'b1;
    #1;
    check("idle_in_ready", a_in_ready, 1'b1);

    // core_finish in IDLE is ignored.
    a_core_finish = 1'b1;
    tick();
    a_core_finish = 1'b0;
    check("idle_finish_busy", a_busy, 1'b0);
    check("idle_finish_out_valid", a_out_valid, 1'b0);

    // Frame 1: diagonal H, uniform y/N, finish pulse mid-load.
    for (int k = 0; k < 40; k++)
      words[k] = (k < 16 && (k / 4) == (k % 4)) ? 16'h0100 : 16'h0019;
    send_a(0, 19, 1'b0);
    a_core_finish = 1'b1;
    tick();
    a_core_finish = 1'b0;
    check("load_finish_busy", a_busy, 1'b1);
    check("load_finish_start", a_core_start, 1'b0);
    check("load_finish_out_valid", a_out_valid, 1'b0);
    send_a(20, 39, 1'b0);
    finish_drain_a(16'h0100, 1'b0);
    check("frame_cnt_1", a_frame_cnt, 16'd1);

    // Frame 2: distinct words, gapped input, output stall mid-drain.
    for (int k = 0; k < 40; k++) words[k] = 16'(16'h1000 + k);
    send_a(0, 39, 1'b1);
    finish_drain_a(16'h2000, 1'b1);
    check("frame_cnt_2", a_frame_cnt, 16'd2);

    // Frame 3: reset after 20 words, then a full frame.
    for (int k = 0; k < 40; k++) words[k] = 16'(16'h3000 + k);
    send_a(0, 19, 1'b0);
    reset = 1'b0;
    #1;
    check("abort_busy", a_busy, 1'b0);
    check("abort_in_ready", a_in_ready, 1'b0);
    check("abort_h_flat", a_h_flat, '0);
    check("abort_frame_cnt", a_frame_cnt, 16'h0);
    tick();
    reset = 1'b1;
    repeat (3) begin
      check("abort_no_start", a_core_start, 1'b0);
      tick();
    end
    send_a(0, 39, 1'b0);
    finish_drain_a(16'h3100, 1'b0);
    check("frame_cnt_after_abort", a_frame_cnt, 16'd1);

    // Small instance: 10 words, 2 output words.
    for (int k = 0; k < 10; k++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(16'h0500 + k);
      tick();
    end
    b_in_valid = 1'b0;
    check("b_start", b_core_start, 1'b1);
    check("b_h_flat", b_h_flat, 64'h0503_0502_0501_0500);
    check("b_y_flat", b_y_flat, 32'h0505_0504);
    check("b_n_flat", b_n_flat, 64'h0509_0508_0507_0506);
    repeat (3) tick();
    b_x_flat      = 32'h0B02_0B01;
    b_core_finish = 1'b1;
    tick();
    b_core_finish = 1'b0;
    check("b_word0", b_out_data, 16'h0B01);
    check("b_last0", b_out_last, 1'b0);
    tick();
    check("b_word1", b_out_data, 16'h0B02);
    check("b_last1", b_out_last, 1'b1);
    tick();
    check("b_out_valid_after", b_out_valid, 1'b0);
    check("b_frame_cnt", b_frame_cnt, 16'd1);

`ifdef MMSE_LOADER_TIMEOUT_EN
    // Watchdog: no finish, start held exactly TIMEOUT cycles.
    begin
      int cyc;
      for (int k = 0; k < 40; k++) words[k] = 16'(16'h6000 + k);
      send_a(0, 39, 1'b0);
      cyc = 0;
      while (a_core_start && cyc < 100) begin
        cyc++;
        tick();
      end
      check("wd_wait_cycles", cyc, 16);
      check("wd_timeout_err", a_timeout_err, 1'b1);
      check("wd_busy", a_busy, 1'b0);
      check("wd_out_valid", a_out_valid, 1'b0);
      check("wd_frame_cnt", a_frame_cnt, 16'd1);
      send_a(0, 0, 1'b0);
      check("wd_next_frame", a_busy, 1'b1);
      check("wd_err_sticky", a_timeout_err, 1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
